// File: rtl/my_riscv_defines.sv
// Shared definitions for the machine-mode trap controller:
// FSM states, CSR addresses, cause codes and system opcodes.
package my_riscv_defines;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_TRAP,
    ST_RET,
    ST_SLEEP,
    ST_WAKE
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_ECALL = 32'd11;
  localparam logic [31:0] MCAUSE_MEI   = 32'h8000_000B;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI   = 32'h1050_0073;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/my_trap_csr.sv
// Machine trap CSRs (mstatus/mtvec/mepc/mcause) and their read mux.
// Trap and return updates take priority over datapath writes.
module my_trap_csr
  import my_riscv_defines::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        trap_set,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic        ret_set,
  output logic [31:0] csr_rdata,
  output logic        mie,
  output logic [31:0] mtvec_base,
  output logic [31:0] mepc_val
);

  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mtvec  <= RESET_MTVEC;
      mepc   <= '0;
      mcause <= '0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie  <= csr_wdata[3];
            mpie <= csr_wdata[7];
          end
          CSR_MTVEC:  mtvec  <= csr_wdata;
          CSR_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
          CSR_MCAUSE: mcause <= csr_wdata;
          default: ;
        endcase
      end
      // later assignments win over the datapath write above
      if (trap_set) begin
        mpie   <= mie;
        mie    <= 1'b0;
        mcause <= trap_cause;
        mepc   <= {trap_epc[31:2], 2'b00};
      end else if (ret_set) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = {24'b0, mpie, 3'b0, mie, 3'b0};
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      default:     csr_rdata = '0;
    endcase
  end

  assign mtvec_base = {mtvec[31:2], 2'b00};
  assign mepc_val   = mepc;

endmodule

// File: rtl/my_trap_ctrl.sv
// Machine-mode trap/return/sleep controller for the execute stage.
// Redirects fetch one cycle after an ECALL, MRET, WFI wake or interrupt.
module my_trap_ctrl
  import my_riscv_defines::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        instr_ready_o,
  output logic        flush_o,
  output logic        pc_set_o,
  output logic [31:0] pc_target_o
);

  trap_state_e state, state_nxt;

  logic [31:0] wfi_pc, wfi_pc_nxt;
  logic        trap_set;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        ret_set;
  logic        mie;
  logic [31:0] mtvec_base;
  logic [31:0] mepc_val;
  logic        csr_we;

  logic is_ecall, is_mret, is_wfi;

  assign is_ecall = (instr_i == INSTR_ECALL);
  assign is_mret  = (instr_i == INSTR_MRET);
  assign is_wfi   = (instr_i == INSTR_WFI);
  assign csr_we   = csr_we_i && (state == ST_RUN);

  my_trap_csr #(
    .RESET_MTVEC(RESET_MTVEC)
  ) u_csr (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr_i),
    .csr_wdata (csr_wdata_i),
    .trap_set  (trap_set),
    .trap_cause(trap_cause),
    .trap_epc  (trap_epc),
    .ret_set   (ret_set),
    .csr_rdata (csr_rdata_o),
    .mie       (mie),
    .mtvec_base(mtvec_base),
    .mepc_val  (mepc_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      wfi_pc <= '0;
    end else begin
      state  <= state_nxt;
      wfi_pc <= wfi_pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wfi_pc_nxt = wfi_pc;
    trap_set   = 1'b0;
    trap_cause = '0;
    trap_epc   = '0;
    ret_set    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (instr_valid_i) begin
          if (irq_i && mie) begin
            state_nxt  = ST_TRAP;
            trap_set   = 1'b1;
            trap_cause = MCAUSE_MEI;
            trap_epc   = pc_i;
          end else begin
            unique case (1'b1)
              is_ecall: begin
                state_nxt  = ST_TRAP;
                trap_set   = 1'b1;
                trap_cause = MCAUSE_ECALL;
                trap_epc   = pc_i;
              end
              is_mret: begin
                state_nxt = ST_RET;
                ret_set   = 1'b1;
              end
              is_wfi: begin
                state_nxt  = ST_SLEEP;
                wfi_pc_nxt = pc_i;
              end
              default: ;
            endcase
          end
        end
      end
      ST_TRAP:  state_nxt = ST_RUN;
      ST_RET:   state_nxt = ST_RUN;
      ST_SLEEP: if (irq_i) state_nxt = ST_WAKE;
      ST_WAKE: begin
        if (mie) begin
          state_nxt  = ST_TRAP;
          trap_set   = 1'b1;
          trap_cause = MCAUSE_MEI;
          trap_epc   = pc_plus4(wfi_pc);
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    instr_ready_o = 1'b0;
    flush_o       = 1'b0;
    pc_set_o      = 1'b0;
    pc_target_o   = '0;
    unique case (state)
      ST_RUN: instr_ready_o = 1'b1;
      ST_TRAP: begin
        flush_o     = 1'b1;
        pc_set_o    = 1'b1;
        pc_target_o = mtvec_base;
      end
      ST_RET: begin
        flush_o     = 1'b1;
        pc_set_o    = 1'b1;
        pc_target_o = mepc_val;
      end
      ST_SLEEP: ;
      ST_WAKE: begin
        if (!mie) begin
          flush_o     = 1'b1;
          pc_set_o    = 1'b1;
          pc_target_o = pc_plus4(wfi_pc);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_my_trap_ctrl.sv
// Directed bench for my_trap_ctrl; redirects are checked by a
// scoreboard monitor, CSR state by inline checks.
module tb_my_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        irq_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        instr_ready_o;
  logic        flush_o;
  logic        pc_set_o;
  logic [31:0] pc_target_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic        run_done = 1'b0;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] WFI   = 32'h1050_0073;

  my_trap_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid_i(instr_valid_i),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .irq_i        (irq_i),
    .csr_we_i     (csr_we_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_rdata_o  (csr_rdata_o),
    .instr_ready_o(instr_ready_o),
    .flush_o      (flush_o),
    .pc_set_o     (pc_set_o),
    .pc_target_o  (pc_target_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a,
                    input logic [31:0] exp);
    csr_addr_i = a;
    #1;
    chk(name, csr_rdata_o, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    tick();
    csr_we_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    pc_i          = pc;
    tick();
    instr_valid_i = 1'b0;
    instr_i       = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, instr_ready_o}, 32'd1);
    chk({tag, "_flush"}, {31'b0, flush_o}, 32'd0);
    chk({tag, "_pcset"}, {31'b0, pc_set_o}, 32'd0);
    chk({tag, "_target"}, pc_target_o, 32'd0);
    rd({tag, "_mstatus"}, 12'h300, 32'h0);
    rd({tag, "_mtvec"}, 12'h305, 32'h100);
    rd({tag, "_mepc"}, 12'h341, 32'h0);
    rd({tag, "_mcause"}, 12'h342, 32'h0);
  endtask

  // Scoreboard monitor: every redirect must match the next expected target
  always @(negedge clk) begin
    if (!rst && pc_set_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL redirect_unexpected: got target %h want none",
                 pc_target_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc_target_o !== e || flush_o !== 1'b1) begin
          n_bad++;
          $display("FAIL redirect: got target %h flush %b want %h flush 1",
                   pc_target_o, flush_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!run_done) begin
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst           = 1'b1;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    pc_i          = '0;
    irq_i         = 1'b0;
    csr_we_i      = 1'b0;
    csr_addr_i    = '0;
    csr_wdata_i   = '0;
    tick();
    chk_reset_vals("during_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("after_rst");
    rd("unmapped_rd", 12'h123, 32'h0);

    // ECALL -> trap to mtvec
    wr(12'h305, 32'h200);
    wr(12'h300, 32'h8);
    exp_q.push_back(32'h200);
    issue(ECALL, 32'h40);
    chk("trap_ready", {31'b0, instr_ready_o}, 32'd0);
    rd("ecall_mepc", 12'h341, 32'h40);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h80);
    tick();

    // MRET -> back to mepc, MIE restored
    exp_q.push_back(32'h40);
    issue(MRET, 32'h90);
    rd("mret_mstatus", 12'h300, 32'h88);
    tick();
    chk("mret_run_ready", {31'b0, instr_ready_o}, 32'd1);

    // WFI with MIE=0, wake without trapping
    wr(12'h300, 32'h0);
    issue(WFI, 32'h80);
    for (int i = 0; i < 5; i++) begin
      chk("sleep_ready", {31'b0, instr_ready_o}, 32'd0);
      tick();
    end
    wr(12'h305, 32'h999);
    rd("sleep_wr_ignored", 12'h305, 32'h200);
    irq_i = 1'b1;
    exp_q.push_back(32'h84);
    tick();
    irq_i = 1'b0;
    chk("wake_ready", {31'b0, instr_ready_o}, 32'd0);
    tick();
    rd("wfi_mcause_kept", 12'h342, 32'd11);

    // WFI with MIE=1, wake traps with mepc = wfi_pc + 4
    wr(12'h300, 32'h8);
    issue(WFI, 32'h80);
    irq_i = 1'b1;
    tick();
    exp_q.push_back(32'h200);
    tick();
    irq_i = 1'b0;
    rd("wake_mepc", 12'h341, 32'h84);
    rd("wake_mcause", 12'h342, 32'h8000_000B);
    rd("wake_mstatus", 12'h300, 32'h80);
    tick();

    // Interrupt beats ECALL; trap beats concurrent mstatus write
    wr(12'h300, 32'h8);
    irq_i       = 1'b1;
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h300;
    csr_wdata_i = 32'h8;
    exp_q.push_back(32'h200);
    issue(ECALL, 32'h60);
    irq_i    = 1'b0;
    csr_we_i = 1'b0;
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc", 12'h341, 32'h60);
    rd("irq_mstatus", 12'h300, 32'h80);
    tick();

    // Unaffected CSR write lands in the same cycle as ECALL
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h305;
    csr_wdata_i = 32'h300;
    exp_q.push_back(32'h300);
    issue(ECALL, 32'h44);
    csr_we_i = 1'b0;
    rd("same_cyc_mtvec", 12'h305, 32'h300);
    rd("same_cyc_mepc", 12'h341, 32'h44);
    tick();
    wr(12'h341, 32'h43);
    rd("mepc_lowbits", 12'h341, 32'h40);

    // pc+4 wraps to zero
    issue(WFI, 32'hFFFF_FFFC);
    irq_i = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    irq_i = 1'b0;
    tick();

    // Reset while sleeping
    issue(WFI, 32'h100);
    tick();
    chk("pre_rst_sleep", {31'b0, instr_ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_sleep");

    // Reset while in TRAP
    exp_q.push_back(32'h100);
    issue(ECALL, 32'h20);
    chk("pre_rst_trap", {31'b0, pc_set_o}, 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_trap");

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    run_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_trap_ctrl.md
MY_TRAP_CTRL -- requirements
Module: my_trap_ctrl

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h0000_0100, reset trap-vector base (bits[1:0] ignored).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports instr_valid_i  in  1 and instr_i  in  32, the instruction in execute and its valid flag.
REQ-005 SHALL have port pc_i  in  32  PC of instr_i.
REQ-006 SHALL have port irq_i  in  1  level machine external interrupt.
REQ-007 SHALL have ports csr_we_i in 1, csr_addr_i in 12, csr_wdata_i in 32: datapath CSR write (already-computed value).
REQ-008 SHALL have port csr_rdata_o  out  32  combinational read of csr_addr_i.
REQ-009 SHALL have ports instr_ready_o out 1, flush_o out 1, pc_set_o out 1, pc_target_o out 32: execute acceptance, pipeline flush, fetch redirect.

Function
REQ-010 SHALL implement FSM states RUN, TRAP, RET, SLEEP, WAKE; outputs decoded from registered state only.
REQ-011 In RUN: instr_ready_o=1; flush_o=pc_set_o=0; pc_target_o=0.
REQ-012 RUN, instr_valid_i, irq_i, MIE=1 -> TRAP, cause 32'h8000_000B, mepc<=pc_i (instruction not retired); interrupt beats any instruction match.
REQ-013 RUN, instr_valid_i, instr_i==32'h0000_0073 (ECALL) -> TRAP, cause 32'd11, mepc<=pc_i.
REQ-014 RUN, instr_valid_i, instr_i==32'h3020_0073 (MRET) -> RET.
REQ-015 RUN, instr_valid_i, instr_i==32'h1050_0073 (WFI) -> SLEEP, wfi_pc<=pc_i.
REQ-016 TRAP (one cycle): flush_o=1, pc_set_o=1, pc_target_o={mtvec[31:2],2'b00}, instr_ready_o=0; MPIE<=MIE, MIE<=0, mcause/mepc committed on entry edge; -> RUN.
REQ-017 RET (one cycle): flush_o=1, pc_set_o=1, pc_target_o=mepc; MIE<=MPIE, MPIE<=1; -> RUN.
REQ-018 SLEEP: instr_ready_o=0, flush_o=0, pc_set_o=0; stays until irq_i=1 (MIE ignored), then -> WAKE.
REQ-019 WAKE: if MIE=1 -> TRAP, cause 32'h8000_000B, mepc<=wfi_pc+4; else flush_o=1, pc_set_o=1, pc_target_o=wfi_pc+4, -> RUN.
REQ-020 Minimum latency detect->redirect: 1 cycle (match on edge N, pc_set_o high in cycle N+1).
REQ-021 CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mtvec 0x305, mepc 0x341 (bits[1:0] read 0), mcause 0x342; other addresses read 0, writes ignored.
REQ-022 CSR writes honored only when state==RUN; same-cycle trap/MRET update of a field SHALL override csr_we_i to that field.
REQ-023 csr_we_i in same cycle as instruction match SHALL still update unaffected CSRs.
REQ-024 pc+4 arithmetic SHALL be 32-bit modulo (0xFFFF_FFFC+4 -> 0).

Reset
REQ-025 rst=1 on a clock edge SHALL force state RUN, MIE=0, MPIE=0, mepc=0, mcause=0, mtvec=RESET_MTVEC, wfi_pc=0, from any state including SLEEP/TRAP mid-operation.
REQ-026 During and after reset: instr_ready_o=1, flush_o=0, pc_set_o=0, pc_target_o=0.

Structure
REQ-027 FSM state enum, CSR addresses, mcause codes, and ECALL/MRET/WFI encodings SHALL live in shared package my_riscv_defines.
REQ-028 A sub-module my_trap_csr SHALL hold mstatus/mtvec/mepc/mcause and the read mux; FSM stays in my_trap_ctrl.

Verification
REQ-029 ECALL at pc 0x40, mtvec=0x200, MIE=1 -> next cycle pc_set_o=1, target 0x200, mepc=0x40, mcause=11, MIE=0, MPIE=1.
REQ-030 MRET after REQ-029 -> next cycle target 0x40, MIE=1, MPIE=1, state RUN.
REQ-031 WFI at 0x80, MIE=0, irq_i after 5 cycles -> instr_ready_o=0 throughout, then target 0x84, no mcause change.
REQ-032 WFI at 0x80, MIE=1, irq_i -> WAKE then TRAP, mepc=0x84, mcause=0x8000_000B, target mtvec.
REQ-033 irq_i with MIE=1 coincident with ECALL -> mcause=0x8000_000B, mepc=ECALL pc; csr_we_i to mstatus same cycle loses to trap update.
REQ-034 rst asserted in SLEEP and in TRAP -> next cycle RUN, all outputs/CSRs at REQ-025/026 values, mtvec=RESET_MTVEC.
